// File: rtl/maple_rx_sequencer.sv
// Purpose: Maple bus receive sequencer; turns line edge strobes into 32-bit words plus frame status.
// Latency: a completed word appears on word_data/word_valid one clk after its 32nd bit strobe.
// Backpressure: one-word holding register; a word completing while the previous one is unconsumed aborts the frame (OVERFLOW).
//
// Ports:
//   clk, reset (async, active-low)           clock and reset
//   rx_enable                                arms the receiver, looked at only while IDLE
//   sdcka_level, sdckb_level                 synchronized line levels
//   sdcka/sdckb_posedge/negedge              single-cycle edge strobes
//   end_frame, end_frame_error               strobes from the end-pattern decoder
//   word_data/word_valid/word_ready          received word handshake
//   frame_done, frame_error                  single-cycle frame outcome pulses
//   error_code, word_count, busy             status
module maple_rx_sequencer #(
  parameter logic [15:0] TIMEOUT   = 16'd5000,
  parameter logic [8:0]  MAX_WORDS = 9'd256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_enable,
  input  logic        sdcka_level,
  input  logic        sdckb_level,
  input  logic        sdcka_posedge,
  input  logic        sdcka_negedge,
  input  logic        sdckb_posedge,
  input  logic        sdckb_negedge,
  input  logic        end_frame,
  input  logic        end_frame_error,
  output logic [31:0] word_data,
  output logic        word_valid,
  input  logic        word_ready,
  output logic        frame_done,
  output logic        frame_error,
  output logic [2:0]  error_code,
  output logic [8:0]  word_count,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_DONE,
    S_ERROR
  } state_t;

  localparam logic [2:0] ERR_BAD_START = 3'd1;
  localparam logic [2:0] ERR_TIMEOUT   = 3'd2;
  localparam logic [2:0] ERR_END       = 3'd3;
  localparam logic [2:0] ERR_LENGTH    = 3'd4;
  localparam logic [2:0] ERR_OVERFLOW  = 3'd5;
  localparam logic [2:0] ERR_TOO_LONG  = 3'd6;

  state_t      state;
  state_t      state_nxt;
  logic [2:0]  start_cnt;
  logic [4:0]  bit_cnt;
  logic [31:0] shift_reg;
  logic [15:0] idle_cnt;

  logic        any_edge;
  logic        timeout_hit;
  logic        bit_stb;
  logic        bit_in;
  logic        frame_start;
  logic        shift_en;
  logic        word_load;
  logic        err_set;
  logic [2:0]  err_code_nxt;

  assign any_edge = sdcka_posedge | sdcka_negedge | sdckb_posedge | sdckb_negedge;
  // Fires on the TIMEOUT-th consecutive cycle without any edge strobe.
  assign timeout_hit = !any_edge && ((idle_cnt + 16'd1) == TIMEOUT);
  // A falling samples B, B falling samples A.
  assign bit_stb = sdcka_negedge | sdckb_negedge;
  assign bit_in  = sdcka_negedge ? sdckb_level : sdcka_level;
  assign busy    = (state != S_IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    frame_start  = 1'b0;
    shift_en     = 1'b0;
    word_load    = 1'b0;
    err_set      = 1'b0;
    err_code_nxt = 3'd0;
    case (state)
      S_IDLE: begin
        if (sdcka_negedge && sdckb_level && rx_enable) begin
          state_nxt   = S_START;
          frame_start = 1'b1;
        end
      end
      S_START: begin
        if (end_frame_error) begin
          err_set      = 1'b1;
          err_code_nxt = ERR_END;
        end else if (timeout_hit) begin
          err_set      = 1'b1;
          err_code_nxt = ERR_TIMEOUT;
        end else if (sdcka_posedge) begin
          if (start_cnt == 3'd4) begin
            state_nxt = S_DATA;
          end else begin
            err_set      = 1'b1;
            err_code_nxt = ERR_BAD_START;
          end
        end
      end
      S_DATA: begin
        if (end_frame_error) begin
          err_set      = 1'b1;
          err_code_nxt = ERR_END;
        end else if (timeout_hit) begin
          err_set      = 1'b1;
          err_code_nxt = ERR_TIMEOUT;
        end else if (end_frame) begin
          // Up to three trailing bits are the end pattern's own edges.
          if (bit_cnt <= 5'd3) begin
            state_nxt = S_DONE;
          end else begin
            err_set      = 1'b1;
            err_code_nxt = ERR_LENGTH;
          end
        end else if (bit_stb) begin
          if (bit_cnt == 5'd31) begin
            if (word_count == MAX_WORDS) begin
              err_set      = 1'b1;
              err_code_nxt = ERR_TOO_LONG;
            end else if (word_valid && !word_ready) begin
              err_set      = 1'b1;
              err_code_nxt = ERR_OVERFLOW;
            end else begin
              shift_en  = 1'b1;
              word_load = 1'b1;
            end
          end else begin
            shift_en = 1'b1;
          end
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      S_ERROR: begin
        if (sdcka_level && sdckb_level) begin
          state_nxt = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
    if (err_set) begin
      state_nxt = S_ERROR;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      start_cnt   <= 3'd0;
      bit_cnt     <= 5'd0;
      shift_reg   <= 32'd0;
      idle_cnt    <= 16'd0;
      word_data   <= 32'd0;
      word_valid  <= 1'b0;
      frame_done  <= 1'b0;
      frame_error <= 1'b0;
      error_code  <= 3'd0;
      word_count  <= 9'd0;
    end else begin
      frame_done  <= (state_nxt == S_DONE);
      frame_error <= err_set;

      if (frame_start) begin
        start_cnt  <= 3'd0;
        bit_cnt    <= 5'd0;
        shift_reg  <= 32'd0;
        word_count <= 9'd0;
        error_code <= 3'd0;
      end

      if ((state == S_START) && sdckb_negedge && (start_cnt != 3'd7)) begin
        start_cnt <= start_cnt + 3'd1;
      end

      if ((state == S_START) || (state == S_DATA)) begin
        idle_cnt <= any_edge ? 16'd0 : idle_cnt + 16'd1;
      end else begin
        idle_cnt <= 16'd0;
      end

      if (shift_en) begin
        shift_reg <= {shift_reg[30:0], bit_in};
        bit_cnt   <= bit_cnt + 5'd1;
      end

      // A fresh word may land in the same cycle the old one is taken.
      if (word_load) begin
        word_data  <= {shift_reg[30:0], bit_in};
        word_valid <= 1'b1;
        word_count <= word_count + 9'd1;
      end else if (word_valid && word_ready) begin
        word_valid <= 1'b0;
      end

      if (err_set) begin
        error_code <= err_code_nxt;
      end
    end
  end

endmodule

// File: tb/tb_maple_rx_sequencer.sv
module tb_maple_rx_sequencer;

  localparam int T    = 60;
  localparam int MAXW = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        rx_enable;
  logic        sdcka_level, sdckb_level;
  logic        sdcka_posedge, sdcka_negedge, sdckb_posedge, sdckb_negedge;
  logic        end_frame, end_frame_error;
  logic [31:0] word_data;
  logic        word_valid;
  logic        word_ready;
  logic        frame_done;
  logic        frame_error;
  logic [2:0]  error_code;
  logic [8:0]  word_count;
  logic        busy;

  maple_rx_sequencer #(
    .TIMEOUT   (16'd60),
    .MAX_WORDS (9'd3)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .rx_enable       (rx_enable),
    .sdcka_level     (sdcka_level),
    .sdckb_level     (sdckb_level),
    .sdcka_posedge   (sdcka_posedge),
    .sdcka_negedge   (sdcka_negedge),
    .sdckb_posedge   (sdckb_posedge),
    .sdckb_negedge   (sdckb_negedge),
    .end_frame       (end_frame),
    .end_frame_error (end_frame_error),
    .word_data       (word_data),
    .word_valid      (word_valid),
    .word_ready      (word_ready),
    .frame_done      (frame_done),
    .frame_error     (frame_error),
    .error_code      (error_code),
    .word_count      (word_count),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  // Model state: expected words with the cycle they must become visible,
  // and the cycles where the single-cycle outcome pulses must appear.
  logic [31:0] wq_d[$];
  int          wq_t[$];
  logic [31:0] got_q[$];
  int          exp_done_at = -1;
  int          exp_err_at  = -1;
  int          last_err_cyc = -1;
  int          n_done = 0;
  int          drv_cyc = 0;
  int          m_bits = 0;
  int          m_words = 0;
  logic [31:0] m_acc = '0;
  int          c0;

  task automatic chk1(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (reset) begin
      chk1("frame_done", frame_done, cyc == exp_done_at);
      chk1("frame_error", frame_error, cyc == exp_err_at);
      chk1("word_valid", word_valid, (wq_d.size() != 0) && (wq_t[0] <= cyc));
      if (frame_done) n_done++;
      if (frame_error) last_err_cyc = cyc;
      if (word_valid && word_ready && (wq_d.size() != 0)) begin
        chk32("word_data", word_data, wq_d[0]);
        got_q.push_back(word_data);
        void'(wq_d.pop_front());
        void'(wq_t.pop_front());
      end
    end
  end

  task automatic drive(input logic an, input logic ap, input logic bn, input logic bp,
                       input logic ef, input logic efe);
    sdcka_negedge   = an;
    sdcka_posedge   = ap;
    sdckb_negedge   = bn;
    sdckb_posedge   = bp;
    end_frame       = ef;
    end_frame_error = efe;
    drv_cyc = cyc;
    @(posedge clk);
    #1;
    sdcka_negedge   = 1'b0;
    sdcka_posedge   = 1'b0;
    sdckb_negedge   = 1'b0;
    sdckb_posedge   = 1'b0;
    end_frame       = 1'b0;
    end_frame_error = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic begin_frame();
    sdcka_level = 1'b0;
    sdckb_level = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    m_bits = 0;
    m_words = 0;
    m_acc = '0;
    idle(1);
  endtask

  task automatic start_pulses(input int n);
    for (int i = 0; i < n; i++) begin
      sdckb_level = 1'b0;
      drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      idle(1);
      sdckb_level = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      idle(1);
    end
  endtask

  // A rises after the start pulses: only exactly four pulses lead into data.
  task automatic enter_data(input int n_pulses);
    sdcka_level = 1'b1;
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    if (n_pulses != 4) exp_err_at = drv_cyc + 1;
  endtask

  task automatic send_bit(input logic b);
    if (m_bits % 2 == 0) begin
      sdckb_level = b;
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end else begin
      sdcka_level = b;
      drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    end
    m_acc = {m_acc[30:0], b};
    m_bits++;
    if (m_bits % 32 == 0) begin
      if (m_words == MAXW) exp_err_at = drv_cyc + 1;
      else if ((wq_d.size() != 0) && !word_ready) exp_err_at = drv_cyc + 1;
      else begin
        wq_d.push_back(m_acc);
        wq_t.push_back(drv_cyc + 1);
        m_words++;
      end
    end
    idle(1);
  endtask

  task automatic send_bits(input logic [31:0] w, input int n);
    for (int i = 31; i > 31 - n; i--) send_bit(w[i]);
  endtask

  task automatic end_ok();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    if ((m_bits % 32) <= 3) exp_done_at = drv_cyc + 1;
    else exp_err_at = drv_cyc + 1;
    idle(1);
  endtask

  task automatic lines_high();
    sdcka_level = 1'b1;
    sdckb_level = 1'b1;
    idle(2);
  endtask

  task automatic good_frame();
    word_ready = 1'b1;
    begin_frame();
    chk1("busy_in_frame", busy, 1'b1);
    start_pulses(4);
    enter_data(4);
    send_bits(32'hDEADBEEF, 32);
    send_bits(32'h12345678, 32);
    send_bit(1'b1);
    send_bit(1'b1);
    end_ok();
    idle(2);
    chk32("good_word_count", 32'(word_count), 32'd2);
    chk1("good_busy_after", busy, 1'b0);
    chk32("good_word0", (got_q.size() > 0) ? got_q[0] : 32'hxxxxxxxx, 32'hDEADBEEF);
    chk32("good_word1", (got_q.size() > 1) ? got_q[1] : 32'hxxxxxxxx, 32'h12345678);
    got_q.delete();
  endtask

  initial begin
    reset = 1'b0;
    rx_enable = 1'b1;
    word_ready = 1'b1;
    sdcka_level = 1'b1;
    sdckb_level = 1'b1;
    sdcka_posedge = 1'b0;
    sdcka_negedge = 1'b0;
    sdckb_posedge = 1'b0;
    sdckb_negedge = 1'b0;
    end_frame = 1'b0;
    end_frame_error = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk32("rst_word_data", word_data, 32'd0);
    chk1("rst_word_valid", word_valid, 1'b0);
    chk1("rst_frame_done", frame_done, 1'b0);
    chk1("rst_frame_error", frame_error, 1'b0);
    chk32("rst_error_code", 32'(error_code), 32'd0);
    chk32("rst_word_count", 32'(word_count), 32'd0);
    chk1("rst_busy", busy, 1'b0);
    reset = 1'b1;
    idle(2);

    // Disarmed receiver ignores a start edge.
    rx_enable = 1'b0;
    sdcka_level = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(2);
    chk1("disarmed_busy", busy, 1'b0);
    rx_enable = 1'b1;
    lines_high();

    // Two clean words.
    good_frame();
    chk32("good_done_pulses", n_done, 32'd1);

    // Three start pulses; B held low so the abort waits for the lines.
    begin_frame();
    start_pulses(3);
    sdckb_level = 1'b0;
    enter_data(3);
    idle(3);
    chk1("bad_start_wait_busy", busy, 1'b1);
    chk32("bad_start_code", 32'(error_code), 32'd1);
    sdckb_level = 1'b1;
    idle(2);
    chk1("bad_start_idle", busy, 1'b0);

    // Overflow: consumer stalled across two word completions.
    word_ready = 1'b0;
    begin_frame();
    chk32("code_cleared_on_start", 32'(error_code), 32'd0);
    start_pulses(4);
    enter_data(4);
    send_bits(32'hA5A50F0F, 32);
    send_bits(32'h11112222, 32);
    idle(2);
    chk32("overflow_code", 32'(error_code), 32'd5);
    chk32("overflow_count", 32'(word_count), 32'd1);
    word_ready = 1'b1;
    idle(2);
    chk32("overflow_held_word", (got_q.size() > 0) ? got_q[0] : 32'hxxxxxxxx, 32'hA5A50F0F);
    got_q.delete();
    lines_high();

    // Lines frozen after the start pattern.
    begin_frame();
    start_pulses(4);
    enter_data(4);
    c0 = drv_cyc;
    exp_err_at = c0 + T + 1;
    idle(T - 1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(2);
    chk32("timeout_code", 32'(error_code), 32'd2);
    chk32("timeout_latency", last_err_cyc - c0, 32'd61);
    lines_high();

    // Same, with end_frame_error in the timeout cycle.
    begin_frame();
    start_pulses(4);
    enter_data(4);
    c0 = drv_cyc;
    exp_err_at = c0 + T + 1;
    idle(T - 1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(2);
    chk32("end_error_code", 32'(error_code), 32'd3);
    lines_high();

    // end_frame after 40 bits.
    begin_frame();
    start_pulses(4);
    enter_data(4);
    send_bits(32'h0F0F0F0F, 32);
    send_bits(32'hFF000000, 8);
    end_ok();
    idle(2);
    chk32("length_code", 32'(error_code), 32'd4);
    got_q.delete();
    lines_high();

    // end_frame after 35 bits, rx_enable dropped mid-frame.
    begin_frame();
    start_pulses(4);
    enter_data(4);
    rx_enable = 1'b0;
    send_bits(32'hCAFEF00D, 32);
    send_bits(32'hE0000000, 3);
    end_ok();
    idle(2);
    chk32("short_tail_count", 32'(word_count), 32'd1);
    chk32("short_tail_code", 32'(error_code), 32'd0);
    chk32("short_tail_word", (got_q.size() > 0) ? got_q[0] : 32'hxxxxxxxx, 32'hCAFEF00D);
    got_q.delete();
    rx_enable = 1'b1;
    lines_high();

    // One word more than MAX_WORDS.
    begin_frame();
    start_pulses(4);
    enter_data(4);
    send_bits(32'h00000001, 32);
    send_bits(32'h00000002, 32);
    send_bits(32'h00000003, 32);
    send_bits(32'h00000004, 32);
    idle(2);
    chk32("too_long_code", 32'(error_code), 32'd6);
    chk32("too_long_count", 32'(word_count), 32'd3);
    got_q.delete();
    lines_high();

    // Reset mid-data, then a clean frame.
    begin_frame();
    start_pulses(4);
    enter_data(4);
    send_bits(32'h55AA33CC, 32);
    send_bits(32'hFFFFFFFF, 8);
    reset = 1'b0;
    wq_d.delete();
    wq_t.delete();
    exp_done_at = -1;
    exp_err_at = -1;
    #2;
    chk32("midrst_word_data", word_data, 32'd0);
    chk1("midrst_word_valid", word_valid, 1'b0);
    chk32("midrst_word_count", 32'(word_count), 32'd0);
    chk1("midrst_busy", busy, 1'b0);
    chk1("midrst_frame_error", frame_error, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    got_q.delete();
    lines_high();
    good_frame();

    idle(3);
    chk32("words_outstanding", wq_d.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/maple_rx_sequencer.md
MAPLE_RX_SEQUENCER -- requirements
Module: maple_rx_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16'd5000: clk cycles with no line edge before a frame is aborted.
REQ-002 SHALL have parameter MAX_WORDS, default 9'd256: maximum number of complete words per frame.
REQ-003 SHALL have the following ports, clock and reset first:
  clk  input  1  system clock
  reset  input  1  asynchronous, active-low
  rx_enable  input  1  arms the receiver; sampled only in IDLE
  sdcka_level, sdckb_level  input  1 each  synchronized line levels
  sdcka_posedge, sdcka_negedge, sdckb_posedge, sdckb_negedge  input  1 each  single-cycle edge strobes
  end_frame, end_frame_error  input  1 each  single-cycle strobes from the end-frame decoder
  word_data  output  32  received word, MSB first
  word_valid  output  1  word_data holds an unconsumed word
  word_ready  input  1  consumer accepts word_data when both are high
  frame_done  output  1  single-cycle pulse: frame received cleanly
  frame_error  output  1  single-cycle pulse: frame aborted
  error_code  output  3  cause of the last abort; held until the next frame starts
  word_count  output  9  complete words in the current/last frame
  busy  output  1  high in every state except IDLE

Function
REQ-004 SHALL implement states IDLE, START, DATA, DONE and ERROR.
REQ-005 IDLE→START SHALL occur on sdcka_negedge while sdckb_level=1 and rx_enable=1; the entry cycle SHALL clear word_count, the start count, the bit count and error_code.
REQ-006 In START, each sdckb_negedge SHALL increment a 3-bit start count that saturates at 7; no bits SHALL be sampled.
REQ-007 START→DATA SHALL occur on sdcka_posedge when the start count is 4; any other count SHALL go to ERROR with code 1 (BAD_START).
REQ-008 In DATA, sdcka_negedge SHALL shift in sdckb_level and sdckb_negedge SHALL shift in sdcka_level, MSB first, into a 32-bit shift register.
REQ-009 A 5-bit bit counter SHALL wrap from 31 to 0; the 32nd bit SHALL load word_data and set word_valid in the next cycle, and increment word_count.
REQ-010 word_valid SHALL remain high until the cycle after word_valid and word_ready are both high.
REQ-011 Completion of a word while word_valid=1 and word_ready=0 SHALL go to ERROR with code 5 (OVERFLOW); word_data SHALL keep the old word.
REQ-012 Completion of a word when word_count already equals MAX_WORDS SHALL go to ERROR with code 6 (TOO_LONG).
REQ-013 end_frame in DATA with bit counter ≤3 SHALL discard the partial bits (end-pattern edges) and go to DONE; with bit counter >3 it SHALL go to ERROR with code 4 (LENGTH).
REQ-014 end_frame_error in START or DATA SHALL go to ERROR with code 3 (END_ERROR).
REQ-015 A 16-bit idle counter SHALL clear on any edge strobe and increment otherwise in START/DATA; reaching TIMEOUT SHALL go to ERROR with code 2 (TIMEOUT).
REQ-016 When several events occur in the same cycle, priority SHALL be end_frame_error > timeout > end_frame > bit sample/word completion.
REQ-017 DONE SHALL assert frame_done for exactly one cycle, then return to IDLE; a pending word_valid SHALL be unaffected.
REQ-018 ERROR SHALL assert frame_error in its entry cycle only, then wait until sdcka_level=1 and sdckb_level=1 before returning to IDLE.
REQ-019 rx_enable deasserting outside IDLE SHALL NOT abort the frame in progress.
REQ-020 In ERROR, word_valid SHALL be held until the pending word is consumed; no new words SHALL be produced.

Reset
REQ-021 reset=0 SHALL asynchronously force IDLE, word_data=0, word_valid=0, frame_done=0, frame_error=0, error_code=0, word_count=0, busy=0, and clear all counters, including mid-frame.

Verification
REQ-022 Start pattern of 4 B pulses, 64 bits of 0xDEADBEEF then 0x12345678, end pattern with end_frame; word_ready=1 -> two words in order, word_count=2, one frame_done pulse.
REQ-023 Start pattern of 3 B pulses then A rises -> frame_error pulse, error_code=1, return to IDLE once both lines are high.
REQ-024 Two words completed with word_ready=0 -> first word held, frame_error, error_code=5.
REQ-025 Lines frozen after the start for TIMEOUT cycles -> frame_error exactly at TIMEOUT, error_code=2; end_frame_error asserted in the same cycle -> error_code=3 instead.
REQ-026 end_frame after 40 bits -> error_code=4; end_frame after 35 bits -> frame_done, word_count=1.
REQ-027 reset pulsed low mid-DATA -> all outputs at reset values immediately; next valid frame is received correctly.
